seg_scan_driver: RTL

//  Time-multiplexed driver for a DIGITS-wide common-select 7-segment display.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: blank code, hex decode table, width helper.
package seg_pkg;

  // Active-high "all segments off" before output polarity is applied.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high {g,f,e,d,c,b,a} codes, indexed by nibble value (entry 15 is leftmost).
  localparam logic [15:0][6:0] SEG_DECODE = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment code.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  assign code = SEG_DECODE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous shadow update.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of the committed frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 500,
  parameter bit          SEG_ACT_LO = 1'b1,
  parameter bit          SEL_ACT_LO = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_in,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int unsigned CntW = idx_width(SCAN_DIV);
  localparam int unsigned IdxW = idx_width(DIGITS);
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);
  localparam logic [7:0]        SegIdle = SEG_ACT_LO ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] SelIdle = SEL_ACT_LO ? '1 : '0;

  logic [CntW-1:0]          cnt_q;
  logic [IdxW-1:0]          idx_q;
  logic                     pend_q;
  logic [DIGITS-1:0][3:0]   pend_data_q, shadow_data_q, commit_data, in_data;
  logic [DIGITS-1:0]        pend_dp_q, pend_en_q;
  logic [DIGITS-1:0]        shadow_dp_q, shadow_en_q, shadow_blank_q;
  logic [DIGITS-1:0]        commit_dp, commit_en, commit_blank;
  logic [7:0]               seg_q, seg_d, seg_act;
  logic [DIGITS-1:0]        sel_q, sel_d, sel_act;
  logic                     frame_done_q;
  logic                     frame_end, commit;
  logic [6:0]               digit_code;

  assign in_data   = data_in;
  assign frame_end = (cnt_q == CntMax) && (idx_q == IdxMax);
  // A load on the boundary cycle bypasses the pending regs into the new frame.
  assign commit      = frame_end && (load || pend_q);
  assign commit_data = load ? in_data : pend_data_q;
  assign commit_dp   = load ? dp_in   : pend_dp_q;
  assign commit_en   = load ? en_in   : pend_en_q;

`ifdef SEG_SCAN_LZB_EN
  logic higher_dark;
  always_comb begin
    commit_blank = '0;
    higher_dark  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      commit_blank[i] = higher_dark && (commit_data[i] == 4'h0) && !commit_dp[i];
      if (commit_en[i] && !commit_blank[i]) higher_dark = 1'b0;
    end
  end
`else
  always_comb begin
    commit_blank = '0;
  end
`endif

  seg_hex_decode u_hex_decode (
    .nibble (shadow_data_q[idx_q]),
    .code   (digit_code)
  );

  always_comb begin
    seg_act = SEG_OFF;
    sel_act = '0;
    if (cnt_q >= BlankEnd) begin
      sel_act[idx_q] = 1'b1;
      if (shadow_en_q[idx_q] && !shadow_blank_q[idx_q]) begin
        seg_act = {shadow_dp_q[idx_q], digit_code};
      end
    end
    seg_d = seg_act ^ {8{SEG_ACT_LO}};
    sel_d = sel_act ^ {DIGITS{SEL_ACT_LO}};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      pend_q         <= 1'b0;
      pend_data_q    <= '0;
      pend_dp_q      <= '0;
      pend_en_q      <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_en_q    <= '0;
      shadow_blank_q <= '0;
      seg_q          <= SegIdle;
      sel_q          <= SelIdle;
      frame_done_q   <= 1'b0;
    end else begin
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load) begin
        pend_data_q <= in_data;
        pend_dp_q   <= dp_in;
        pend_en_q   <= en_in;
      end
      if (frame_end) begin
        pend_q <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
      if (commit) begin
        shadow_data_q  <= commit_data;
        shadow_dp_q    <= commit_dp;
        shadow_en_q    <= commit_en;
        shadow_blank_q <= commit_blank;
      end
      frame_done_q <= frame_end;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule
